axi_burst_master: RTL and testbench

AXI4 initiator that turns a simple command/stream interface into single INCR bursts. It drives the AR/R path for reads and the AW/W/B path for writes on an axi_channel master modport. It is the counterpart to our AXI BRAM slave controller, used by DMA-style engines and test harnesses. One transaction is outstanding at a time; reads and writes are serialised.

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_burst_master_if.sv | 74 +++++++
 rtl/axi_burst_master.sv | 169 ++++++++++++++++
 tb/tb_axi_burst_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, response merge helper and the burst-master FSM state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
    S_WR_RESP = 3'd5,
    S_RSP     = 3'd6,
    S_DRAIN   = 3'd7
  } state_e;

  // Response codes are ordered by severity, so the worst of two is the larger.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] size_of(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) with initiator and target modports.
interface axi_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator driven by a command/stream interface.
// Optional: define AXI_MASTER_4K_CHECK_EN to reject bursts that cross a 4 KiB boundary.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  axi_channel.master              axi,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_last,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_resp
);

  localparam int         BYTES    = DATA_WIDTH / 8;
  localparam logic [2:0] AXI_SIZE = size_of(DATA_WIDTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [1:0]              resp_q, resp_d;
  logic                    crosses_4k;

`ifdef AXI_MASTER_4K_CHECK_EN
  logic [31:0] burst_end;
  assign burst_end  = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES);
  assign crosses_4k = burst_end > 32'd4096;
`else
  assign crosses_4k = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = cmd_len;
          resp_d = RESP_OKAY;
          if (crosses_4k) begin
            resp_d  = RESP_SLVERR;
            state_d = cmd_write ? S_DRAIN : S_RSP;
          end else begin
            state_d = cmd_write ? S_WR_ADDR : S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: if (axi.ar_ready) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (axi.r_valid && rdata_ready) begin
          resp_d = resp_worst(resp_q, axi.r_resp);
          cnt_d  = cnt_q - 8'd1;
          if (axi.r_last) state_d = S_RSP;
        end
      end
      S_WR_ADDR: if (axi.aw_ready) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (wdata_valid && axi.w_ready) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi.b_valid) begin
          resp_d  = axi.b_resp;
          state_d = S_RSP;
        end
      end
      S_RSP: if (rsp_ready) state_d = S_IDLE;
      S_DRAIN: begin
        if (wdata_valid) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_RSP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);

  assign axi.ar_valid = (state_q == S_RD_ADDR);
  assign axi.ar_id    = ID_WIDTH'(0);
  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = len_q;
  assign axi.ar_size  = AXI_SIZE;
  assign axi.ar_burst = BURST_INCR;
  assign axi.ar_lock  = 1'b0;
  assign axi.ar_cache = 4'd0;
  assign axi.ar_prot  = 3'd0;
  assign axi.ar_qos   = 4'd0;

  assign axi.aw_valid = (state_q == S_WR_ADDR);
  assign axi.aw_id    = ID_WIDTH'(0);
  assign axi.aw_addr  = addr_q;
  assign axi.aw_len   = len_q;
  assign axi.aw_size  = AXI_SIZE;
  assign axi.aw_burst = BURST_INCR;
  assign axi.aw_lock  = 1'b0;
  assign axi.aw_cache = 4'd0;
  assign axi.aw_prot  = 3'd0;
  assign axi.aw_qos   = 4'd0;

  // Stream sides are straight pass-throughs, gated so nothing leaks outside the owning state.
  assign axi.w_valid  = (state_q == S_WR_DATA) && wdata_valid;
  assign axi.w_data   = wdata;
  assign axi.w_strb   = wstrb;
  assign axi.w_last   = (state_q == S_WR_DATA) && (cnt_q == 8'd0);
  assign wdata_ready  = ((state_q == S_WR_DATA) && axi.w_ready) || (state_q == S_DRAIN);

  assign axi.r_ready  = (state_q == S_RD_DATA) && rdata_ready;
  assign rdata_valid  = (state_q == S_RD_DATA) && axi.r_valid;
  assign rdata        = axi.r_data;
  assign rdata_last   = (state_q == S_RD_DATA) && axi.r_last;

  assign axi.b_ready  = (state_q == S_WR_RESP);
  assign rsp_valid    = (state_q == S_RSP);
  assign rsp_resp     = resp_q;

  a_cmd_aligned: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == S_IDLE && cmd_valid) |-> ((cmd_addr % ADDR_WIDTH'(BYTES)) == '0));
  a_rlast_count: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == S_RD_DATA && axi.r_valid && axi.r_ready) |-> (axi.r_last == (cnt_q == 8'd0)));
  a_r_id_zero: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == S_RD_DATA && axi.r_valid) |-> (axi.r_id == '0));
  a_b_id_zero: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == S_WR_RESP && axi.b_valid) |-> (axi.b_id == '0));

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: vector table of bursts plus reset and 4 KiB sequences.
module tb_axi_burst_master;

  localparam int AW = 48;
  localparam int DW = 64;

  logic          clk;
  logic          resetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_resp;

  axi_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1)) axi_if ();

  axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1)) dut (
    .clk(clk), .resetn(resetn), .axi(axi_if),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0;

  always @(posedge clk) begin
    if (axi_if.ar_valid && axi_if.ar_ready) ar_hs <= ar_hs + 1;
    if (axi_if.aw_valid && axi_if.aw_ready) aw_hs <= aw_hs + 1;
    if (axi_if.w_valid && axi_if.w_ready) w_hs <= w_hs + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [63:0] dbase;
    int          addr_wait;
    int          stall_at;
    int          stall_n;
    bit          wgap;
    int          err1_at;
    logic [1:0]  err1;
    int          err2_at;
    logic [1:0]  err2;
    logic [1:0]  bresp;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[8];

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0; wstrb = '0; rdata_ready = 0; rsp_ready = 0;
    axi_if.aw_ready = 0; axi_if.w_ready = 0; axi_if.ar_ready = 0;
    axi_if.b_valid = 0; axi_if.b_resp = 0; axi_if.b_id = '0;
    axi_if.r_valid = 0; axi_if.r_data = '0; axi_if.r_resp = 0; axi_if.r_last = 0; axi_if.r_id = '0;
  endtask

  task automatic rsp_phase(input logic [1:0] exp_resp);
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_resp", rsp_resp, exp_resp);
    check("cmd_ready_busy", cmd_ready, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    #1;
    check("rsp_valid_done", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int ar0, aw0, w0, b, stall_left;
    bit gap;
    @(negedge clk);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    #1 check("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    for (int i = 0; i < v.addr_wait; i++) begin
      #1;
      check("ax_valid_hold", v.wr ? axi_if.aw_valid : axi_if.ar_valid, 1);
      check("ax_addr_hold", v.wr ? axi_if.aw_addr : axi_if.ar_addr, v.addr);
      @(negedge clk);
    end
    if (v.wr) axi_if.aw_ready = 1; else axi_if.ar_ready = 1;
    #1;
    check("ax_valid", v.wr ? axi_if.aw_valid : axi_if.ar_valid, 1);
    check("ax_other_valid", v.wr ? axi_if.ar_valid : axi_if.aw_valid, 0);
    check("ax_addr", v.wr ? axi_if.aw_addr : axi_if.ar_addr, v.addr);
    check("ax_len", v.wr ? axi_if.aw_len : axi_if.ar_len, v.len);
    check("ax_size", v.wr ? axi_if.aw_size : axi_if.ar_size, 3);
    check("ax_burst", v.wr ? axi_if.aw_burst : axi_if.ar_burst, 1);
    check("ax_id", v.wr ? axi_if.aw_id : axi_if.ar_id, 0);
    check("w_before_aw", axi_if.w_valid, 0);
    @(negedge clk);
    axi_if.aw_ready = 0; axi_if.ar_ready = 0;
    #1 check("ax_valid_drop", v.wr ? axi_if.aw_valid : axi_if.ar_valid, 0);
    b = 0;
    if (!v.wr) begin
      stall_left = v.stall_n;
      while (b <= int'(v.len)) begin
        axi_if.r_valid = 1;
        axi_if.r_data  = v.dbase + 64'(b);
        axi_if.r_resp  = (b == v.err1_at) ? v.err1 : (b == v.err2_at) ? v.err2 : 2'd0;
        axi_if.r_last  = (b == int'(v.len));
        rdata_ready    = !(b == v.stall_at && stall_left > 0);
        #1;
        check("rdata_valid", rdata_valid, 1);
        check("r_ready", axi_if.r_ready, rdata_ready);
        if (rdata_ready) begin
          check("rdata", rdata, v.dbase + 64'(b));
          check("rdata_last", rdata_last, (b == int'(v.len)));
          b++;
        end else begin
          stall_left--;
        end
        @(negedge clk);
      end
      axi_if.r_valid = 0; axi_if.r_last = 0; rdata_ready = 0;
      check("ar_once", ar_hs - ar0, 1);
    end else begin
      axi_if.w_ready = 1;
      gap = 0;
      while (b <= int'(v.len)) begin
        if (v.wgap && gap) begin
          wdata_valid = 0;
          #1 check("w_valid_gap", axi_if.w_valid, 0);
        end else begin
          wdata_valid = 1;
          wdata = v.dbase + 64'(b);
          wstrb = 8'hF0 | 8'(b);
          #1;
          check("w_valid", axi_if.w_valid, 1);
          check("w_data", axi_if.w_data, v.dbase + 64'(b));
          check("w_strb", axi_if.w_strb, 8'hF0 | 8'(b));
          check("w_last", axi_if.w_last, (b == int'(v.len)));
          check("wdata_ready", wdata_ready, 1);
          b++;
        end
        gap = !gap;
        @(negedge clk);
      end
      wdata_valid = 0; axi_if.w_ready = 0;
      #1 check("b_ready", axi_if.b_ready, 1);
      axi_if.b_valid = 1; axi_if.b_resp = v.bresp;
      @(negedge clk);
      axi_if.b_valid = 0;
      check("aw_once", aw_hs - aw0, 1);
      check("w_beats", w_hs - w0, int'(v.len) + 1);
    end
    rsp_phase(v.exp_resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 48'h40,  8'd0, 64'h0000_0000_DEAD_BEEF, 0, -1, 0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd0, 2'd0};
    vecs[1] = '{1'b1, 48'h100, 8'd3, 64'h1111_0000_0000_0000, 0, -1, 0, 1'b1, -1, 2'd0, -1, 2'd0, 2'd0, 2'd0};
    vecs[2] = '{1'b0, 48'h200, 8'd7, 64'hA5A5_0000_0000_0000, 2,  3, 5, 1'b0, -1, 2'd0, -1, 2'd0, 2'd0, 2'd0};
    vecs[3] = '{1'b0, 48'h300, 8'd3, 64'h3333_0000_0000_0000, 0, -1, 0, 1'b0,  1, 2'd2,  2, 2'd3, 2'd0, 2'd3};
    vecs[4] = '{1'b1, 48'h400, 8'd1, 64'h4444_0000_0000_0000, 1, -1, 0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd2, 2'd2};
    vecs[5] = '{1'b0, 48'h500, 8'd2, 64'h5555_0000_0000_0000, 0, -1, 0, 1'b0,  0, 2'd2, -1, 2'd0, 2'd0, 2'd2};
    vecs[6] = '{1'b0, 48'hFC0, 8'd7, 64'h6666_0000_0000_0000, 0, -1, 0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd0, 2'd0};
    vecs[7] = '{1'b1, 48'h700, 8'd0, 64'h7777_0000_0000_0000, 0, -1, 0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd3, 2'd3};

    idle_inputs();
    resetn = 0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ar_valid", axi_if.ar_valid, 0);
    check("rst_aw_valid", axi_if.aw_valid, 0);
    check("rst_w_valid", axi_if.w_valid, 0);
    check("rst_r_ready", axi_if.r_ready, 0);
    check("rst_b_ready", axi_if.b_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    repeat (2) @(negedge clk);
    resetn = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of beat 2 of a six-beat write.
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 48'h600; cmd_len = 8'd5;
    @(negedge clk);
    cmd_valid = 0; axi_if.aw_ready = 1;
    @(negedge clk);
    axi_if.aw_ready = 0; axi_if.w_ready = 1; wdata_valid = 1; wdata = 64'h60;
    @(negedge clk);
    wdata = 64'h61;
    @(negedge clk);
    wdata = 64'h62;
    #1 check("mid_w_valid", axi_if.w_valid, 1);
    resetn = 0;
    #1;
    check("mid_rst_w_valid", axi_if.w_valid, 0);
    check("mid_rst_wdata_ready", wdata_ready, 0);
    check("mid_rst_aw_valid", axi_if.aw_valid, 0);
    check("mid_rst_b_ready", axi_if.b_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    idle_inputs();
    @(negedge clk);
    resetn = 1;
    #1 check("post_rst_cmd_ready", cmd_ready, 1);
    run_vec(vecs[1]);

`ifdef AXI_MASTER_4K_CHECK_EN
    begin
      int aw0, ar0;
      aw0 = aw_hs; ar0 = ar_hs;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 48'hFF8; cmd_len = 8'd1;
      #1 check("x4k_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 0;
      for (int k = 0; k < 2; k++) begin
        wdata_valid = 1; wdata = 64'(k);
        #1;
        check("x4k_aw_valid", axi_if.aw_valid, 0);
        check("x4k_w_valid", axi_if.w_valid, 0);
        check("x4k_drain_ready", wdata_ready, 1);
        @(negedge clk);
      end
      wdata_valid = 0;
      rsp_phase(2'd2);
      @(negedge clk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 48'hFC8; cmd_len = 8'd7;
      @(negedge clk);
      cmd_valid = 0;
      #1 check("x4k_ar_valid", axi_if.ar_valid, 0);
      check("x4k_rdata_valid", rdata_valid, 0);
      rsp_phase(2'd2);
      check("x4k_no_aw", aw_hs - aw0, 0);
      check("x4k_no_ar", ar_hs - ar0, 0);
    end
`else
    run_vec('{1'b1, 48'hFF8, 8'd1, 64'h8888_0000_0000_0000, 0, -1, 0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd0, 2'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
